// File: rtl/sha256_pkg.sv
// sha256_pkg: state encoding and block-layout constants shared by the SHA-256 feed sequencer.
package sha256_pkg;
   typedef enum logic [2:0] {IDLE, MSG, PAD, ZERO, LENHI, LENLO, KICK, WAIT} feed_state_t;
   localparam int SHA256_BLOCK_WORDS = 16;
   localparam logic [31:0] SHA256_PAD_WORD = 32'h80000000;
   localparam int SHA256_LEN_WORD_IDX = 14;
endpackage

// File: rtl/sha256_last_word_pad.sv
// sha256_last_word_pad: keeps the r leading message bits of a partial last word and appends the marker bit.
module sha256_last_word_pad
   import sha256_pkg::*;
(
   input  logic [31:0] dat,
   input  logic [4:0]  r,
   output logic [31:0] word
);
   assign word = (dat & ~(32'hFFFFFFFF >> r)) | (SHA256_PAD_WORD >> r);
endmodule

// File: rtl/sha256_feed_ctrl.sv
// sha256_feed_ctrl: pads a host message stream into 16-word SHA-256 blocks,
// writes them to the engine FIFO and starts the engine once per block.
module sha256_feed_ctrl
   import sha256_pkg::*;
#(
   parameter int FIFO_MIN_DEPTH = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_i,
   input  logic [31:0] bitlen_i,
   input  logic        msg_vld_i,
   input  logic [31:0] msg_dat_i,
   output logic        msg_rdy_o,
   output logic        fifo_wr_en_o,
   output logic [31:0] fifo_wr_dat_o,
   input  logic        fifo_full_i,
   input  logic        eng_ready_i,
   output logic        eng_start_o,
   output logic        busy_o,
   output logic        done_o,
   output logic        err_o
);
   feed_state_t state, nstate, resume, after, fill;
   logic [3:0]  wcnt;
   logic [27:0] words_left;
   logic [23:0] blk_left;
   logic [31:0] len, pad_word, wdat;
   logic        eng_start, busy, err, done, fire, last, final_blk, legal;

   if (FIFO_MIN_DEPTH < SHA256_BLOCK_WORDS) begin : g_depth_chk
      $error("FIFO_MIN_DEPTH must hold at least one full block");
   end

   sha256_last_word_pad u_pad (.dat(msg_dat_i), .r(len[4:0]), .word(pad_word));

   // after: phase following the current write, used directly or parked in resume across a KICK
   always_comb begin
      legal     = bitlen_i[2:0] == 3'd0;
      last      = words_left == 28'd1;
      final_blk = blk_left == 24'd1;
      fire      = (state inside {MSG, PAD, ZERO, LENHI, LENLO}) && !fifo_full_i && (state != MSG || msg_vld_i);
      wdat      = state == MSG ? ((last && len[4:0] != 5'd0) ? pad_word : msg_dat_i)
                : state == PAD ? SHA256_PAD_WORD
                : state == LENLO ? len : 32'd0;
      fill      = (final_blk && wcnt == 4'(SHA256_LEN_WORD_IDX - 1)) ? LENHI : ZERO;
      after     = state == MSG ? (!last ? MSG : (len[4:0] == 5'd0 ? PAD : fill))
                : state == LENHI ? LENLO : fill;
      nstate    = state;
      case (state)
         IDLE:    if (start_i && legal) nstate = bitlen_i == 32'd0 ? PAD : MSG;
         KICK:    if (eng_start && !eng_ready_i) nstate = WAIT;
         WAIT:    if (eng_ready_i) nstate = final_blk ? IDLE : resume;
         default: if (fire) nstate = wcnt == 4'(SHA256_BLOCK_WORDS - 1) ? KICK : after;
      endcase
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state      <= IDLE;
         resume     <= IDLE;
         wcnt       <= '0;
         words_left <= '0;
         blk_left   <= '0;
         len        <= '0;
         eng_start  <= 1'b0;
         busy       <= 1'b0;
         err        <= 1'b0;
         done       <= 1'b0;
      end else begin
         state     <= nstate;
         eng_start <= state == KICK && eng_ready_i;
         done      <= state == WAIT && eng_ready_i && final_blk;
         if (state == IDLE && start_i) begin
            err <= !legal;
            if (legal) begin
               busy       <= 1'b1;
               len        <= bitlen_i;
               wcnt       <= '0;
               words_left <= 28'(({1'b0, bitlen_i} + 33'd31) >> 5);
               blk_left   <= 24'(({1'b0, bitlen_i} + 33'd64) >> 9) + 24'd1;
            end
         end
         if (fire) begin
            wcnt <= wcnt + 4'd1;
            if (state == MSG) words_left <= words_left - 28'd1;
            if (wcnt == 4'(SHA256_BLOCK_WORDS - 1)) resume <= after;
         end
         if (state == WAIT && eng_ready_i) begin
            if (final_blk) busy <= 1'b0;
            else blk_left <= blk_left - 24'd1;
         end
      end

   assign msg_rdy_o     = state == MSG && !fifo_full_i;
   assign fifo_wr_en_o  = fire;
   assign fifo_wr_dat_o = fire ? wdat : 32'd0;
   assign eng_start_o   = eng_start;
   assign busy_o        = busy;
   assign done_o        = done;
   assign err_o         = err;
endmodule

// File: tb/tb_sha256_feed_ctrl.sv
// tb_sha256_feed_ctrl: table vectors, randomized runs against a byte-level padding model, and corner sequences.
module tb_sha256_feed_ctrl;
   logic        clk, rst, start, msg_vld, fifo_full, eng_ready;
   logic [31:0] bitlen, msg_dat;
   logic        msg_rdy_o, fifo_wr_en_o, eng_start_o, busy_o, done_o, err_o;
   logic [31:0] fifo_wr_dat_o;
   logic [37:0] outs;

   sha256_feed_ctrl #(.FIFO_MIN_DEPTH(16)) dut (
      .clk(clk), .rst(rst), .start_i(start), .bitlen_i(bitlen),
      .msg_vld_i(msg_vld), .msg_dat_i(msg_dat), .msg_rdy_o(msg_rdy_o),
      .fifo_wr_en_o(fifo_wr_en_o), .fifo_wr_dat_o(fifo_wr_dat_o), .fifo_full_i(fifo_full),
      .eng_ready_i(eng_ready), .eng_start_o(eng_start_o), .busy_o(busy_o),
      .done_o(done_o), .err_o(err_o)
   );

   assign outs = {msg_rdy_o, fifo_wr_en_o, eng_start_o, busy_o, done_o, err_o, fifo_wr_dat_o};

   typedef struct {
      int unsigned len;
      logic [31:0] w0;
      int          full_pct;
      int          vld_pct;
      bit          mid;
      int          blocks;
      logic [31:0] first;
      bit          chk14;
      logic [31:0] w14;
      logic [31:0] last;
   } vec_t;

   vec_t        vecs[8];
   logic [31:0] msg_q[$], exp_q[$], got_q[$];
   int          n_cmp, n_fail, starts, dones, first_wr, rdy_viol, eng_viol, busy_viol, timeout;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, limit 500000 required");
      $fatal(1);
   end

   // engine: drops ready once it sees a start, stays busy for a few cycles, then reports idle
   initial begin
      eng_ready = 1'b1;
      forever begin
         @(negedge clk);
         if (eng_start_o && eng_ready) begin
            eng_ready = 1'b0;
            repeat ($urandom_range(1, 5)) @(negedge clk);
            eng_ready = 1'b1;
         end
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // reference: message bytes, 0x80, zeros to 56 mod 64, then the 64-bit big-endian bit length
   task automatic build_exp(input int unsigned len);
      byte unsigned b[$];
      logic [63:0]  l64;
      exp_q.delete();
      for (int i = 0; i < int'(len / 8); i++) b.push_back(8'(msg_q[i / 4] >> (24 - 8 * (i % 4))));
      b.push_back(8'h80);
      while (b.size() % 64 != 56) b.push_back(8'h00);
      l64 = 64'(len);
      for (int i = 7; i >= 0; i--) b.push_back(8'(l64 >> (8 * i)));
      for (int i = 0; i < b.size(); i += 4) exp_q.push_back({b[i], b[i + 1], b[i + 2], b[i + 3]});
   endtask

   task automatic run_case(input int unsigned len, input logic [31:0] w0, input bit use_w0,
                           input int full_pct, input int vld_pct, input bit mid);
      int   n, idx, post;
      logic prev_start, prev_ready;
      n = int'((len + 31) / 32);
      msg_q.delete();
      got_q.delete();
      for (int i = 0; i < n; i++) msg_q.push_back((i == 0 && use_w0) ? w0 : $urandom);
      build_exp(len);
      starts = 0; dones = 0; first_wr = -1; rdy_viol = 0; eng_viol = 0; busy_viol = 0; timeout = 0;
      idx = 0; post = 0; prev_start = 1'b0;
      @(negedge clk);
      start = 1'b1; bitlen = len; fifo_full = 1'b0; msg_vld = 1'b0; msg_dat = 32'd0;
      #1 prev_ready = eng_ready;
      for (int cyc = 0; cyc < 3000 && post < 3; cyc++) begin
         @(negedge clk);
         start     = mid && (cyc == 5 || cyc == 9);
         bitlen    = cyc == 5 ? 32'd13 : 32'd64;
         fifo_full = int'($urandom_range(0, 99)) < full_pct;
         msg_vld   = idx < n && int'($urandom_range(0, 99)) < vld_pct;
         msg_dat   = idx < n ? msg_q[idx] : 32'hDEADBEEF;
         #1;
         if (prev_start && eng_start_o != prev_ready) eng_viol++;
         if (!prev_start && eng_start_o && !prev_ready) eng_viol++;
         if (eng_start_o && !prev_start) starts++;
         if (done_o) dones++;
         if (dones == 0 && !busy_o) busy_viol++;
         if (fifo_full && msg_rdy_o) rdy_viol++;
         if (fifo_wr_en_o) begin
            if (first_wr < 0) first_wr = cyc;
            got_q.push_back(fifo_wr_dat_o);
         end
         if (msg_vld && msg_rdy_o) idx++;
         prev_start = eng_start_o;
         prev_ready = eng_ready;
         if (dones > 0) post++;
      end
      start = 1'b0;
      msg_vld = 1'b0;
      if (post == 0) timeout = 1;
   endtask

   task automatic check_run(input string tag);
      int mism;
      mism = 0;
      for (int j = 0; j < got_q.size() && j < exp_q.size(); j++) if (got_q[j] !== exp_q[j]) mism++;
      check({tag, "_timeout"}, 64'(timeout), 64'd0);
      check({tag, "_nwords"}, 64'(got_q.size()), 64'(exp_q.size()));
      check({tag, "_data"}, 64'(mism), 64'd0);
      check({tag, "_starts"}, 64'(starts), 64'(exp_q.size() / 16));
      check({tag, "_done"}, 64'(dones), 64'd1);
      check({tag, "_busy_end"}, 64'(busy_o), 64'd0);
      check({tag, "_busy_run"}, 64'(busy_viol), 64'd0);
      check({tag, "_err"}, 64'(err_o), 64'd0);
      check({tag, "_rdy_full"}, 64'(rdy_viol), 64'd0);
      check({tag, "_eng_hs"}, 64'(eng_viol), 64'd0);
   endtask

   initial begin
      int wr, cnt, len;
      n_cmp = 0; n_fail = 0;
      vecs[0] = '{24,   32'h61626300, 0,  100, 0, 1, 32'h61626380, 1, 32'h0,        32'h18};
      vecs[1] = '{0,    32'h0,        0,  100, 0, 1, 32'h80000000, 1, 32'h0,        32'h0};
      vecs[2] = '{448,  32'h01234567, 0,  100, 0, 2, 32'h01234567, 1, 32'h80000000, 32'h1C0};
      vecs[3] = '{512,  32'h89ABCDEF, 50, 100, 0, 2, 32'h89ABCDEF, 0, 32'h0,        32'h200};
      vecs[4] = '{440,  32'h0F0F0F0F, 0,  100, 0, 1, 32'h0F0F0F0F, 1, 32'h0,        32'h1B8};
      vecs[5] = '{8,    32'hABCDEF12, 0,  100, 0, 1, 32'hAB800000, 1, 32'h0,        32'h8};
      vecs[6] = '{1000, 32'hCAFEF00D, 30, 80,  0, 3, 32'hCAFEF00D, 0, 32'h0,        32'h3E8};
      vecs[7] = '{480,  32'h11111111, 0,  100, 1, 2, 32'h11111111, 0, 32'h0,        32'h1E0};
      rst = 1'b1; start = 1'b0; bitlen = 32'd0; msg_vld = 1'b0; msg_dat = 32'd0; fifo_full = 1'b0;
      repeat (3) @(negedge clk);
      #1 check("reset_outs", 64'(outs), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      #1 check("idle_outs", 64'(outs), 64'd0);
      @(negedge clk);
      start = 1'b1;
      bitlen = 32'd13;
      @(negedge clk);
      start = 1'b0;
      #1;
      check("illegal_err", 64'(err_o), 64'd1);
      check("illegal_busy", 64'(busy_o), 64'd0);
      wr = 0;
      repeat (4) begin
         @(negedge clk);
         #1 if (fifo_wr_en_o) wr++;
      end
      check("illegal_writes", 64'(wr), 64'd0);
      check("err_sticky", 64'(err_o), 64'd1);
      for (int i = 0; i < 8; i++) begin
         run_case(vecs[i].len, vecs[i].w0, 1'b1, vecs[i].full_pct, vecs[i].vld_pct, vecs[i].mid);
         check_run($sformatf("v%0d", i));
         check($sformatf("v%0d_blocks", i), 64'(starts), 64'(vecs[i].blocks));
         if (got_q.size() > 15) begin
            check($sformatf("v%0d_first", i), 64'(got_q[0]), 64'(vecs[i].first));
            check($sformatf("v%0d_last", i), 64'(got_q[got_q.size() - 1]), 64'(vecs[i].last));
            if (vecs[i].chk14) check($sformatf("v%0d_w14", i), 64'(got_q[14]), 64'(vecs[i].w14));
         end
         if (vecs[i].full_pct == 0 && vecs[i].vld_pct == 100)
            check($sformatf("v%0d_latency", i), 64'(first_wr), 64'd0);
      end
      for (int k = 0; k < 6; k++) begin
         len = int'($urandom_range(0, 200)) * 8;
         run_case(len, 32'd0, 1'b0, int'($urandom_range(0, 60)), int'($urandom_range(50, 100)), 1'b0);
         check_run($sformatf("rnd%0d_L%0d", k, len));
      end
      @(negedge clk);
      start = 1'b1; bitlen = 32'd512; msg_vld = 1'b1; msg_dat = 32'h5A5A0000; fifo_full = 1'b0;
      @(negedge clk);
      start = 1'b0;
      wr = 0;
      cnt = 0;
      while (wr < 7 && cnt < 100) begin
         #1 if (fifo_wr_en_o) wr++;
         cnt++;
         @(negedge clk);
      end
      check("midrst_words", 64'(wr), 64'd7);
      rst = 1'b1;
      #1 check("midrst_outs", 64'(outs), 64'd0);
      msg_vld = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      run_case(24, 32'h61626300, 1'b1, 0, 100, 1'b0);
      check_run("abc_after_rst");
      if (got_q.size() > 0) check("abc_after_rst_first", 64'(got_q[0]), 64'h61626380);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
